sam_rv32i_pipe: RTL and testbench

Parametrised successor to the team's 5-stage toy RV32 pipeline (IF/ID/EX/MEM/WB). It keeps the same custom encoding. It adds an externally loadable instruction memory, a run gate, and load-use hazard stall. It also adds EX-stage branch resolution with flush, x0 hardwired to zero, and a retirement counter. It is used as the next-generation core for the samsung-riscv task flow and bench.

---
 rtl/sam_rv_pkg.sv | 80 ++++++++
 rtl/sam_rv_alu.sv | 50 +++++
 rtl/sam_rv32i_pipe.sv | 153 +++++++++++++++
 tb/tb_sam_rv32i_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sam_rv_pkg.sv
// Shared encodings, decoded-field and stage-register types for the sam_rv32i_pipe core.
package sam_rv_pkg;

    localparam int unsigned RV_XLEN = 32;

    localparam logic [6:0] OP_AR = 7'd0;
    localparam logic [6:0] OP_M  = 7'd1;
    localparam logic [6:0] OP_BR = 7'd2;
    localparam logic [6:0] OP_SH = 7'd3;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SUB = 3'd1;
    localparam logic [2:0] F3_AND = 3'd2;
    localparam logic [2:0] F3_OR  = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_SLT = 3'd5;
    localparam logic [2:0] F3_SLL = 3'd0;
    localparam logic [2:0] F3_SRL = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd0;
    localparam logic [2:0] F3_SW  = 3'd1;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [RV_XLEN-1:0] imm;
    } dec_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        ir;
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] a;
        logic [RV_XLEN-1:0] b;
        logic [RV_XLEN-1:0] imm;
        logic [RV_XLEN-1:0] aluout;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, ir: NOP_IR, default: '0};

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d.opcode = ir[6:0];
        d.funct3 = ir[14:12];
        d.rd     = ir[11:7];
        d.rs1    = ir[19:15];
        d.rs2    = ir[24:20];
        d.imm    = {{(RV_XLEN-12){ir[31]}}, ir[31:20]};
        return d;
    endfunction

    function automatic logic is_legal(input dec_t d);
        case (d.opcode)
            OP_AR:              return d.funct3 <= F3_SLT;
            OP_M, OP_BR, OP_SH: return d.funct3 <= 3'd1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input dec_t d);
        return (d.opcode == OP_M) && (d.funct3 == F3_LW);
    endfunction

    function automatic logic writes_rd(input dec_t d);
        return (d.opcode == OP_AR) || (d.opcode == OP_SH) || is_load(d);
    endfunction

    // The rs2 field overlaps imm, so only treat it as a source where it is one.
    function automatic logic uses_rs2(input dec_t d);
        return (d.opcode == OP_AR) || (d.opcode == OP_SH) || (d.opcode == OP_BR) ||
               ((d.opcode == OP_M) && (d.funct3 == F3_SW));
    endfunction

endpackage

// File: rtl/sam_rv_alu.sv
// Combinational execute unit: arithmetic/logic/shift result, load/store address, branch decision.
module sam_rv_alu
    import sam_rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);

    always_comb begin
        result       = '0;
        branch_taken = 1'b0;
        case (opcode)
            OP_AR: begin
                case (funct3)
                    F3_ADD:  result = a + b;
                    F3_SUB:  result = a - b;
                    F3_AND:  result = a & b;
                    F3_OR:   result = a | b;
                    F3_XOR:  result = a ^ b;
                    F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                    default: result = '0;
                endcase
            end
            OP_SH: begin
                case (funct3)
                    F3_SLL:  result = a << b[4:0];
                    F3_SRL:  result = a >> b[4:0];
                    default: result = '0;
                endcase
            end
            OP_M:  result = a + imm;
            OP_BR: begin
                case (funct3)
                    F3_BEQ:  branch_taken = (a == b);
                    F3_BNE:  branch_taken = (a != b);
                    default: branch_taken = 1'b0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/sam_rv32i_pipe.sv
// 5-stage toy RV32 pipeline with loadable IMEM, run gate, hazard stalls and EX branch flush.
// Define FORWARDING_EN for EX operand forwarding (load-use stall only); default stalls on EX/MEM hazards.
module sam_rv32i_pipe
    import sam_rv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          RN_N,
    input  logic                          run,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [XLEN-1:0]               NPC,
    output logic [XLEN-1:0]               WB_OUT,
    output logic                          wb_valid,
    output logic [CNT_W-1:0]              retired
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);
    localparam int unsigned RAW = $clog2(NREGS);

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [IAW-1:0]  pc;

    stage_t ifid, idex, exmem, memwb;
    dec_t   id_d, ex_d, mem_d, wb_d;

    logic [XLEN-1:0] id_a, id_b, ex_a, ex_b, alu_result, mem_result, ex_sum;
    logic [IAW-1:0]  ex_target;
    logic            alu_taken, ex_taken, stall, wb_we;

    function automatic logic write_hit(input logic pv, input dec_t p, input logic [4:0] src);
        return pv && writes_rd(p) && (p.rd[RAW-1:0] != '0) && (p.rd[RAW-1:0] == src[RAW-1:0]);
    endfunction

    function automatic logic depends(input logic pv, input dec_t p, input dec_t c);
        return write_hit(pv, p, c.rs1) || (uses_rs2(c) && write_hit(pv, p, c.rs2));
    endfunction

    assign id_d  = decode(ifid.ir);
    assign ex_d  = decode(idex.ir);
    assign mem_d = decode(exmem.ir);
    assign wb_d  = decode(memwb.ir);
    assign wb_we = memwb.valid && writes_rd(wb_d) && (wb_d.rd[RAW-1:0] != '0);
    assign NPC   = XLEN'(pc);

    // Register read with write-through from the instruction retiring this cycle.
    always_comb begin
        id_a = (id_d.rs1[RAW-1:0] == '0) ? '0 : regs[id_d.rs1[RAW-1:0]];
        id_b = (id_d.rs2[RAW-1:0] == '0) ? '0 : regs[id_d.rs2[RAW-1:0]];
        if (write_hit(memwb.valid, wb_d, id_d.rs1)) id_a = memwb.aluout;
        if (write_hit(memwb.valid, wb_d, id_d.rs2)) id_b = memwb.aluout;
    end

`ifdef FORWARDING_EN
    assign stall = ifid.valid && is_legal(id_d) && is_load(ex_d) && depends(idex.valid, ex_d, id_d);

    // Later assignments win, giving EX/MEM priority over MEM/WB.
    always_comb begin
        ex_a = idex.a;
        ex_b = idex.b;
        if (write_hit(memwb.valid, wb_d, ex_d.rs1)) ex_a = memwb.aluout;
        if (write_hit(memwb.valid, wb_d, ex_d.rs2)) ex_b = memwb.aluout;
        if (!is_load(mem_d) && write_hit(exmem.valid, mem_d, ex_d.rs1)) ex_a = exmem.aluout;
        if (!is_load(mem_d) && write_hit(exmem.valid, mem_d, ex_d.rs2)) ex_b = exmem.aluout;
    end
`else
    assign stall = ifid.valid && is_legal(id_d) &&
                   (depends(idex.valid, ex_d, id_d) || depends(exmem.valid, mem_d, id_d));

    always_comb begin
        ex_a = idex.a;
        ex_b = idex.b;
    end
`endif

    sam_rv_alu #(.XLEN(XLEN)) u_alu (
        .opcode       (ex_d.opcode),
        .funct3       (ex_d.funct3),
        .a            (ex_a),
        .b            (ex_b),
        .imm          (idex.imm),
        .result       (alu_result),
        .branch_taken (alu_taken)
    );

    assign ex_taken   = idex.valid && (ex_d.opcode == OP_BR) && alu_taken;
    assign ex_sum     = idex.pc + idex.imm;
    assign ex_target  = ex_sum[IAW-1:0];
    assign mem_result = is_load(mem_d) ? dmem[exmem.aluout[DAW-1:0]] : exmem.aluout;

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk or negedge RN_N) begin
        if (!RN_N) begin
            pc       <= '0;
            ifid     <= BUBBLE;
            idex     <= BUBBLE;
            exmem    <= BUBBLE;
            memwb    <= BUBBLE;
            WB_OUT   <= '0;
            wb_valid <= 1'b0;
            retired  <= '0;
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= (i >= 1 && i <= 6) ? XLEN'(10 * i) : '0;
            for (int unsigned i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= '0;
        end else begin
            if (ex_taken) begin
                pc   <= ex_target;
                ifid <= BUBBLE;
                idex <= BUBBLE;
            end else if (stall) begin
                idex <= BUBBLE;
            end else begin
                idex <= '{valid: ifid.valid && is_legal(id_d), ir: ifid.ir, pc: ifid.pc,
                          a: id_a, b: id_b, imm: id_d.imm, aluout: '0};
                if (run) begin
                    ifid <= '{valid: 1'b1, ir: imem[pc], pc: RV_XLEN'(pc), default: '0};
                    pc   <= pc + 1'b1;
                end else begin
                    ifid <= BUBBLE;
                end
            end

            exmem <= '{valid: idex.valid, ir: idex.ir, pc: idex.pc, a: ex_a, b: ex_b,
                       imm: idex.imm, aluout: alu_result};
            memwb <= '{valid: exmem.valid, ir: exmem.ir, pc: exmem.pc, a: exmem.a, b: exmem.b,
                       imm: exmem.imm, aluout: mem_result};

            if (exmem.valid && (mem_d.opcode == OP_M) && (mem_d.funct3 == F3_SW))
                dmem[exmem.aluout[DAW-1:0]] <= exmem.b;

            wb_valid <= wb_we;
            if (wb_we) begin
                regs[wb_d.rd[RAW-1:0]] <= memwb.aluout;
                WB_OUT                 <= memwb.aluout;
            end
            if (memwb.valid) retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_sam_rv32i_pipe.sv
// Directed bench for sam_rv32i_pipe; expectations are hand-derived per edge after reset release.
module tb_sam_rv32i_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FORWARDING_EN
    localparam int SUB_E    = 6;
    localparam int T2_NPC4  = 4;
    localparam int T2_WB6   = 1;
    localparam int ADD_E    = 8;
    localparam int T3_NPC5  = 4;
`else
    localparam int SUB_E    = 8;
    localparam int T2_NPC4  = 2;
    localparam int T2_WB6   = 0;
    localparam int ADD_E    = 9;
    localparam int T3_NPC5  = 3;
`endif

    logic        clk = 1'b0;
    logic        RN_N, run, imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] NPC, WB_OUT;
    logic        wb_valid;
    logic [15:0] retired;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned edge_n;

    logic [31:0] prog [16];
    logic        wbv  [64];
    logic [31:0] wbo  [64];
    logic [31:0] npcs [64];
    logic [15:0] rets [64];

    sam_rv32i_pipe dut (
        .clk        (clk),
        .RN_N       (RN_N),
        .run        (run),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .NPC        (NPC),
        .WB_OUT     (WB_OUT),
        .wb_valid   (wb_valid),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_op(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = NOP;
    endtask

    // Holds reset while loading IMEM, checks reset outputs, then releases on a falling edge.
    task automatic start(input string tag);
        RN_N    = 1'b0;
        run     = 1'b0;
        imem_we = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_addr  = 6'(i);
            imem_wdata = (i < 16) ? prog[i] : NOP;
            @(negedge clk);
        end
        imem_we = 1'b0;
        check({tag, "_rst_npc"}, NPC, 0);
        check({tag, "_rst_wbout"}, WB_OUT, 0);
        check({tag, "_rst_wbv"}, 32'(wb_valid), 0);
        check({tag, "_rst_ret"}, 32'(retired), 0);
        RN_N   = 1'b1;
        run    = 1'b1;
        edge_n = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
            wbv[edge_n]  = wb_valid;
            wbo[edge_n]  = WB_OUT;
            npcs[edge_n] = NPC;
            rets[edge_n] = retired;
        end
    endtask

    initial begin
        int unsigned n_wb;
        imem_addr  = '0;
        imem_wdata = '0;

        // add r7,r1,r2 alone, then run gate
        clear_prog();
        prog[0] = r_op(7'd0, 3'd0, 5'd7, 5'd1, 5'd2);
        start("t1");
        step(6);
        check("t1_npc_e1", npcs[1], 1);
        check("t1_wbv_e4", 32'(wbv[4]), 0);
        check("t1_wbv_e5", 32'(wbv[5]), 1);
        check("t1_wbout_e5", wbo[5], 30);
        check("t1_ret_e5", 32'(rets[5]), 1);
        check("t1_wbv_e6", 32'(wbv[6]), 0);
        check("t1_ret_e6", 32'(rets[6]), 1);
        run = 1'b0;
        step(3);
        check("t1_npc_hold_e7", npcs[7], 6);
        check("t1_npc_hold_e9", npcs[9], 6);
        run = 1'b1;
        step(1);
        check("t1_npc_resume", npcs[10], 7);

        // RAW dependency add -> sub
        clear_prog();
        prog[0] = r_op(7'd0, 3'd0, 5'd7, 5'd1, 5'd2);
        prog[1] = r_op(7'd0, 3'd1, 5'd8, 5'd7, 5'd1);
        start("t2");
        step(10);
        check("t2_add_wb", wbo[5], 30);
        check("t2_npc_e4", npcs[4], T2_NPC4);
        check("t2_wbv_e6", 32'(wbv[6]), T2_WB6);
        check("t2_sub_wbv", 32'(wbv[SUB_E]), 1);
        check("t2_sub_wb", wbo[SUB_E], 20);
        check("t2_sub_ret", 32'(rets[SUB_E]), 2);

        // sw r5 -> DM[5]; lw r9; add r10,r9,r1
        clear_prog();
        prog[0] = i_op(7'd1, 3'd1, 5'd0, 5'd0, 12'd5);
        prog[1] = i_op(7'd1, 3'd0, 5'd9, 5'd0, 12'd5);
        prog[2] = r_op(7'd0, 3'd0, 5'd10, 5'd9, 5'd1);
        start("t3");
        step(10);
        check("t3_sw_wbv", 32'(wbv[5]), 0);
        check("t3_sw_ret", 32'(rets[5]), 1);
        check("t3_npc_e5", npcs[5], T3_NPC5);
        check("t3_lw_wbv", 32'(wbv[6]), 1);
        check("t3_lw_wb", wbo[6], 50);
        check("t3_gap_wbv", 32'(wbv[ADD_E-1]), 0);
        check("t3_add_wb", wbo[ADD_E], 60);
        check("t3_add_ret", 32'(rets[ADD_E]), 3);

        // beq at PC 2 (rs2 field = r8 = 0) jumps to 10; r11 writers flushed
        clear_prog();
        prog[0]  = r_op(7'd0, 3'd0, 5'd12, 5'd1, 5'd1);
        prog[2]  = i_op(7'd2, 3'd0, 5'd0, 5'd0, 12'd8);
        prog[3]  = r_op(7'd0, 3'd0, 5'd11, 5'd1, 5'd2);
        prog[4]  = r_op(7'd0, 3'd0, 5'd11, 5'd1, 5'd2);
        prog[10] = r_op(7'd0, 3'd0, 5'd13, 5'd11, 5'd2);
        start("t4");
        step(12);
        check("t4_npc_e4", npcs[4], 4);
        check("t4_npc_target", npcs[5], 10);
        check("t4_npc_e6", npcs[6], 11);
        check("t4_add12_wb", wbo[5], 20);
        check("t4_flush_wbv_e8", 32'(wbv[8]), 0);
        check("t4_flush_wbv_e9", 32'(wbv[9]), 0);
        check("t4_r11_zero", wbo[10], 20);
        check("t4_ret", 32'(rets[12]), 3);
        n_wb = 0;
        for (int e = 1; e <= 12; e++) if (wbv[e]) n_wb++;
        check("t4_wb_events", n_wb, 2);

        // add r0 discarded; x0 reads 0
        clear_prog();
        prog[0] = r_op(7'd0, 3'd0, 5'd0, 5'd1, 5'd2);
        prog[1] = r_op(7'd0, 3'd0, 5'd14, 5'd0, 5'd1);
        start("t5");
        step(8);
        check("t5_x0_wbv", 32'(wbv[5]), 0);
        check("t5_x0_wbout", wbo[5], 0);
        check("t5_x0_ret", 32'(rets[5]), 1);
        check("t5_r14_wb", wbo[6], 10);
        check("t5_r14_ret", 32'(rets[6]), 2);

        // mid-program reset, IMEM kept, rerun gives same results
        clear_prog();
        prog[0] = i_op(7'd1, 3'd1, 5'd0, 5'd0, 12'd5);
        prog[1] = i_op(7'd1, 3'd0, 5'd9, 5'd0, 12'd5);
        prog[2] = r_op(7'd0, 3'd0, 5'd10, 5'd9, 5'd1);
        start("t6");
        step(7);
        check("t6_pre_lw", wbo[6], 50);
        RN_N = 1'b0;
        #1;
        check("t6_mid_npc", NPC, 0);
        check("t6_mid_wbout", WB_OUT, 0);
        check("t6_mid_wbv", 32'(wb_valid), 0);
        check("t6_mid_ret", 32'(retired), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        RN_N   = 1'b1;
        run    = 1'b1;
        edge_n = 0;
        step(10);
        check("t6_rerun_npc_e1", npcs[1], 1);
        check("t6_rerun_lw", wbo[6], 50);
        check("t6_rerun_add", wbo[ADD_E], 60);
        check("t6_rerun_ret", 32'(rets[10]), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
